digital_mem_responder: RTL and testbench
========================================

Name: digital_mem_responder

Overview:
- Memory-side responder for the `digital_mem_*` request interface that the SoC drives as initiator.
- Accepts level-held read/write requests, inserts programmable wait states, and performs little-endian byte/half/word accesses on an internal byte-lane SRAM.
- Returns a single-cycle `ready` pulse.
- Sits on the board side of the SoC top and replaces the external memory model for self-contained runs.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address mapped to SRAM offset 0.
- DEPTH_BYTES, 65536, SRAM size in bytes; power of two, multiple of 4.
- WAIT_CYCLES, 2, wait states inserted between request accept and `ready`; range 0..255.
- DATA_W, `MAX_BIT_POS+1` (32), address and data width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- mem_addr  in  DATA_W  byte address; sampled at accept.
- mem_write_en  in  1  write request; level, held by initiator until `ready`.
- mem_read_en  in  1  read request; level, held by initiator until `ready`.
- mem_byte_size  in  4  access size in bytes; legal values 1, 2, 4.
- mem_wdata  in  DATA_W  write data, low-aligned; sampled at accept.
- mem_data  out  DATA_W  read data, zero-extended, low-aligned.
- mem_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle error flag, coincident with `mem_ready`.

Behaviour:
- Reset: rst=0 forces state IDLE, wait counter 0, `mem_ready`=0, `mem_err`=0, `mem_data`=0. SRAM contents are not cleared. Reset mid-access abandons the access; a write not yet committed is lost.
- States:
  - IDLE: if exactly one of read_en/write_en is 1, accept. Latch addr, size, wdata, direction. Counter=WAIT_CYCLES. Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: decrement the counter each cycle; at 1, go to ACCESS.
  - ACCESS: perform the SRAM operation (commit write / capture read), assert `mem_ready` (plus `mem_err` if applicable) for one cycle, go to RELEASE.
  - RELEASE: stay until read_en=0 and write_en=0, then go to IDLE.
  - RELEASE exists so a held request cannot be accepted twice.
- Latency: accept at edge T gives `mem_ready`=1 during cycle T+1+WAIT_CYCLES. With WAIT_CYCLES=0, `ready` is high in the cycle after accept.
- `mem_data` is updated only in ACCESS for reads. It holds its value until the next read completes. Writes leave it unchanged.
- Byte order is little-endian: `wdata[7:0]` goes to the lowest address.
  - Size 2 writes `wdata[15:0]`.
  - Size 4 writes the full word.
  - Reads return the bytes in the same order, with upper bits zero.
- Offset = (addr - ADDR_BASE) mod DEPTH_BYTES (address wrap).
- Error cases:
  - byte_size not in {1,2,4}: `mem_err`=1, no write, read returns 0.
  - Misaligned access (size 2 with addr[0]=1; size 4 with addr[1:0]≠0): `mem_err`=1, no write, read returns 0.
  - An erroring access still completes with `mem_ready`, so the initiator never hangs.
- Both read_en and write_en high in IDLE: not accepted, remain IDLE, no response.
- Request inputs changing during WAIT are ignored; the latched values are used.

Optional Feature:
- Macro: DIGITAL_MEM_BOUNDS_CHK_EN.
- When defined:
  - Any access with addr < ADDR_BASE or addr+size > ADDR_BASE+DEPTH_BYTES completes with `mem_err`=1.
  - Writes are dropped and reads return 0.
- When undefined: no bounds check; the offset wraps modulo DEPTH_BYTES. `mem_err` still reports size and alignment errors.

Decomposition:
- Shared header `digital_mem_defs.vh`, included alongside config.v, holds:
  - state encodings IDLE/WAIT/ACCESS/RELEASE (2 bits);
  - size codes SZ_B=1, SZ_H=2, SZ_W=4;
  - the error-cause localparams.
- One sub-module, `mem_byte_lane_sram`: 4 byte-lane arrays of DEPTH_BYTES/4 entries, word index plus 4-bit byte write-enable, synchronous write, combinational read.
- The responder FSM performs lane steering and zero-extension.

Test Plan:
1. WAIT_CYCLES=2: write addr 0x10, size 4, wdata 0xA1B2C3D4, held. `ready` pulses on the 3rd cycle after accept, err=0. A read of 0x10, size 4, returns 0xA1B2C3D4.
2. Byte write 0x55 to 0x11, then half read at 0x10 (prior word 0xA1B2C3D4) -> `mem_data`=0x0000_55D4. Byte read at 0x13 -> 0x0000_00A1.
3. Half read at 0x11 -> `ready` and `mem_err` both 1, `mem_data`=0. byte_size=3 -> err=1, no SRAM change.
4. Request held for 5 cycles past `ready` -> exactly one `ready` pulse. Drop en for 1 cycle, reassert -> second access accepted and second `ready` seen. read_en and write_en both 1 -> no `ready` for 20 cycles.
5. rst=0 asserted during WAIT of a write to 0x20 -> outputs 0, state IDLE. A later read of 0x20 returns the old content (write not committed).
6. With DIGITAL_MEM_BOUNDS_CHK_EN and DEPTH_BYTES=65536: word read at ADDR_BASE+0xFFFC gives err=0; at ADDR_BASE+0x10000 gives err=1, data 0. Without the macro, the access at +0x10000 aliases offset 0.

Source files
------------

// File: rtl/digital_mem_responder_pkg.sv
// Shared definitions for the digital_mem responder: FSM state encoding,
// access-size codes, error causes and the latched request record.
package digital_mem_responder_pkg;

    localparam int MAX_BIT_POS = 31;
    localparam int DATA_W      = MAX_BIT_POS + 1;
    localparam int NUM_LANES   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SIZE   = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_BOUNDS = 2'd3
    } err_cause_t;

    typedef struct packed {
        logic              is_write;
        logic [DATA_W-1:0] addr;
        logic [3:0]        size;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Size legality and natural alignment, judged on the raw byte address.
    function automatic err_cause_t size_align_chk(input logic [3:0] size,
                                                  input logic [1:0] lo);
        err_cause_t c;
        case (size)
            SZ_B:    c = ERR_NONE;
            SZ_H:    c = lo[0] ? ERR_ALIGN : ERR_NONE;
            SZ_W:    c = (lo != 2'b00) ? ERR_ALIGN : ERR_NONE;
            default: c = ERR_SIZE;
        endcase
        return c;
    endfunction

    // Lane mask of an access that starts in lane 0.
    function automatic logic [NUM_LANES-1:0] size_mask(input logic [3:0] size);
        logic [NUM_LANES-1:0] m;
        case (size)
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/digital_mem_responder_sram.sv
// Byte-lane SRAM: NUM_LANES independent byte arrays sharing one word index.
// Synchronous per-lane write, combinational read. Contents are never reset.
module mem_byte_lane_sram
    import digital_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic [IDX_W-1:0]          idx,
    input  logic [NUM_LANES-1:0]      be,
    input  logic [NUM_LANES-1:0][7:0] wdata,
    output logic [NUM_LANES-1:0][7:0] rdata
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];

        // Lane write, gated by this lane's byte enable.
        always_ff @(posedge clk) begin
            if (be[l]) mem[idx] <= wdata[l];
        end

        assign rdata[l] = mem[idx];
    end

endmodule

// File: rtl/digital_mem_responder.sv
// Memory-side responder for the digital_mem_* request interface.
// Level-held requests are accepted from IDLE, delayed by WAIT_CYCLES, then
// executed on a byte-lane SRAM with a one-cycle mem_ready/mem_err pulse.
// Optional feature macro: DIGITAL_MEM_BOUNDS_CHK_EN (range check against
// ADDR_BASE..ADDR_BASE+DEPTH_BYTES instead of silent address wrap).
module digital_mem_responder
    import digital_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_BYTES = 65536,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic              mem_write_en,
    input  logic              mem_read_en,
    input  logic [3:0]        mem_byte_size,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int         OFF_W     = $clog2(DEPTH_BYTES);
    localparam int         IDX_W     = OFF_W - 2;
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    state_t     state;
    logic [7:0] wait_cnt;
    mem_req_t   req_q;
    mem_req_t   req_cur;

    logic                      accept;
    logic                      do_op;
    logic [OFF_W-1:0]          off;
    logic [1:0]                lane;
    err_cause_t                cause;
    logic                      acc_err;
    logic [NUM_LANES-1:0]      szm;
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] sram_wdata;
    logic [NUM_LANES-1:0][7:0] sram_rdata;
    logic [DATA_W-1:0]         rshift;
    logic [DATA_W-1:0]         rd_val;

    assign accept = (state == ST_IDLE) && (mem_read_en ^ mem_write_en);

    // The operation fires on the edge that enters ACCESS, so the request
    // comes straight from the pins when there are no wait states.
    assign do_op = (accept && (WAIT_CYCLES == 0)) ||
                   ((state == ST_WAIT) && (wait_cnt == 8'd1));

    // Select the request being executed: live pins in IDLE, latched copy otherwise.
    always_comb begin
        req_cur = req_q;
        if (state == ST_IDLE) begin
            req_cur.is_write = mem_write_en;
            req_cur.addr     = mem_addr;
            req_cur.size     = mem_byte_size;
            req_cur.wdata    = mem_wdata;
        end
    end

    // Offset wraps modulo DEPTH_BYTES; only the low OFF_W bits matter.
    assign off  = req_cur.addr[OFF_W-1:0] - ADDR_BASE[OFF_W-1:0];
    assign lane = off[1:0];

`ifdef DIGITAL_MEM_BOUNDS_CHK_EN
    logic [DATA_W:0] end_addr;
    logic [DATA_W:0] limit;
    logic            oob;

    assign end_addr = {1'b0, req_cur.addr} + {{(DATA_W-3){1'b0}}, req_cur.size};
    assign limit    = {1'b0, ADDR_BASE} + (DATA_W+1)'(DEPTH_BYTES);
    assign oob      = (req_cur.addr < ADDR_BASE) || (end_addr > limit);

    // Size/alignment first; a well-formed access may still be out of range.
    always_comb begin
        cause = size_align_chk(req_cur.size, req_cur.addr[1:0]);
        if (cause == ERR_NONE && oob) cause = ERR_BOUNDS;
    end
`else
    // Only size and alignment can fail; out-of-window addresses alias.
    always_comb begin
        cause = size_align_chk(req_cur.size, req_cur.addr[1:0]);
    end
`endif

    assign acc_err = (cause != ERR_NONE);
    assign szm     = size_mask(req_cur.size);

    // Steer low-aligned write data and enables up to the starting lane.
    always_comb begin
        be         = '0;
        sram_wdata = req_cur.wdata << {lane, 3'b000};
        if (do_op && req_cur.is_write && !acc_err) be = szm << lane;
    end

    // Steer read bytes down to lane 0 and zero the lanes beyond the size.
    always_comb begin
        rshift = sram_rdata >> {lane, 3'b000};
        rd_val = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (szm[l]) rd_val[l*8 +: 8] = rshift[l*8 +: 8];
        end
    end

    mem_byte_lane_sram #(
        .DEPTH_WORDS(DEPTH_BYTES / 4)
    ) u_sram (
        .clk  (clk),
        .idx  (off[OFF_W-1:2]),
        .be   (be),
        .wdata(sram_wdata),
        .rdata(sram_rdata)
    );

    // Responder FSM with registered ready/err/data outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_q     <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            mem_data  <= '0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q    <= req_cur;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    if (wait_cnt == 8'd1) state <= ST_ACCESS;
                end
                ST_ACCESS: state <= ST_RELEASE;
                // Hold here until the initiator drops its level request.
                ST_RELEASE: begin
                    if (!mem_read_en && !mem_write_en) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (do_op) begin
                mem_ready <= 1'b1;
                mem_err   <= acc_err;
                if (!req_cur.is_write) mem_data <= acc_err ? '0 : rd_val;
            end
        end
    end

endmodule

// File: tb/tb_digital_mem_responder.sv
// Self-checking bench for digital_mem_responder: constant vector table,
// hand sequences for hold/re-arm/conflict/reset/bounds, then random traffic
// against a byte-array reference model.
module tb_digital_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 65536;
    localparam int          WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_write_en = 1'b0;
    logic        mem_read_en = 1'b0;
    logic [3:0]  mem_byte_size = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    digital_mem_responder #(
        .ADDR_BASE  (BASE),
        .DEPTH_BYTES(DEPTH),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_byte_size(mem_byte_size),
        .mem_wdata    (mem_wdata),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  size;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    // Reference model: flat byte store plus last-read register.
    logic [7:0]  mm [int unsigned];
    logic [31:0] model_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic void model_op(input bit wr, input logic [31:0] a, input logic [3:0] sz,
                                     input logic [31:0] wd, output bit err, output logic [31:0] rd);
        int unsigned off;
        bit legal;
        longint unsigned la, ls;
        legal = (sz == 1) || (sz == 2) || (sz == 4);
        err = !legal;
        if (legal && (a % sz) != 0) err = 1;
`ifdef DIGITAL_MEM_BOUNDS_CHK_EN
        la = longint'(a);
        ls = longint'(sz);
        if (la < longint'(BASE) || la + ls > longint'(BASE) + longint'(DEPTH)) err = 1;
`else
        la = 0;
        ls = 0;
`endif
        rd = 0;
        off = (a - BASE) % DEPTH;
        if (!err) begin
            for (int i = 0; i < sz; i++) begin
                if (wr) mm[(off + i) % DEPTH] = wd[8*i +: 8];
                else    rd[8*i +: 8] = mm[(off + i) % DEPTH];
            end
        end
        if (!wr) model_last = rd;
    endfunction

    // Drive one level-held request from a negedge; scramble the payload
    // while waiting so latching is exercised; hold 'hold' cycles past ready.
    task automatic run_access(input bit wr, input logic [31:0] a, input logic [3:0] sz,
                              input logic [31:0] wd, input int hold, input int idle,
                              output bit rdy, output bit e, output logic [31:0] d,
                              output int lat, output int pulses);
        mem_write_en = wr;
        mem_read_en = !wr;
        mem_addr = a;
        mem_byte_size = sz;
        mem_wdata = wd;
        rdy = 0; e = 0; d = 0; lat = 0; pulses = 0;
        for (int i = 0; i < 40 && !rdy; i++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (mem_ready) begin
                rdy = 1; e = mem_err; d = mem_data; pulses = 1;
            end else begin
                mem_addr = $urandom;
                mem_wdata = $urandom;
                mem_byte_size = 4'($urandom);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready) pulses++;
        end
        mem_write_en = 0;
        mem_read_en = 0;
        for (int i = 0; i < idle; i++) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic do_chk(input string nm, input bit wr, input logic [31:0] a, input logic [3:0] sz,
                          input logic [31:0] wd, input bit xerr, input logic [31:0] xdata);
        bit r, e; logic [31:0] d; int lat, p;
        run_access(wr, a, sz, wd, 0, 2, r, e, d, lat, p);
        chk({nm, "_ready"}, 32'(r), 32'd1);
        chk({nm, "_lat"}, 32'(lat), 32'(1 + WAIT));
        chk({nm, "_err"}, 32'(e), 32'(xerr));
        chk({nm, "_data"}, d, xdata);
    endtask

    initial begin
        bit r, e, xe;
        logic [31:0] d, xd, a, wd;
        logic [3:0] sz;
        int lat, p, cnt;
        logic [3:0] sz_opts [8];
        sz_opts = '{4'd1, 4'd2, 4'd4, 4'd1, 4'd2, 4'd4, 4'd3, 4'd0};

        tbl.push_back('{1, 32'h10, 4, 32'hA1B2C3D4, 0, 32'h0});
        tbl.push_back('{0, 32'h10, 4, 32'h0,        0, 32'hA1B2C3D4});
        tbl.push_back('{1, 32'h11, 1, 32'h00000055, 0, 32'hA1B2C3D4});
        tbl.push_back('{0, 32'h10, 2, 32'h0,        0, 32'h000055D4});
        tbl.push_back('{0, 32'h13, 1, 32'h0,        0, 32'h000000A1});
        tbl.push_back('{0, 32'h11, 2, 32'h0,        1, 32'h0});
        tbl.push_back('{1, 32'h10, 3, 32'hFFFFFFFF, 1, 32'h0});
        tbl.push_back('{0, 32'h10, 4, 32'h0,        0, 32'hA1B255D4});
        tbl.push_back('{1, 32'h12, 4, 32'h01020304, 1, 32'hA1B255D4});
        tbl.push_back('{0, 32'h12, 4, 32'h0,        1, 32'h0});
        tbl.push_back('{1, 32'h20, 4, 32'h11223344, 0, 32'h0});
        tbl.push_back('{1, 32'h22, 2, 32'h7777BEEF, 0, 32'h0});
        tbl.push_back('{0, 32'h20, 4, 32'h0,        0, 32'hBEEF3344});
        tbl.push_back('{0, 32'h22, 2, 32'h0,        0, 32'h0000BEEF});
        tbl.push_back('{1, 32'h23, 1, 32'hFFFFFF99, 0, 32'h0000BEEF});
        tbl.push_back('{0, 32'h20, 4, 32'h0,        0, 32'h99EF3344});
        tbl.push_back('{0, 32'h10, 0, 32'h0,        1, 32'h0});
        tbl.push_back('{0, 32'h10, 8, 32'h0,        1, 32'h0});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_data", mem_data, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table
        foreach (tbl[i])
            do_chk($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].size,
                   tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_data);

        // Held request: exactly one ready; one-cycle drop then re-arm
        run_access(0, 32'h10, 4, 0, 5, 1, r, e, d, lat, p);
        chk("hold_pulses", 32'(p), 32'd1);
        chk("hold_data", d, 32'hA1B255D4);
        run_access(0, 32'h20, 4, 0, 0, 2, r, e, d, lat, p);
        chk("rearm_ready", 32'(r), 32'd1);
        chk("rearm_data", d, 32'h99EF3344);

        // Both enables: never accepted
        mem_read_en = 1; mem_write_en = 1; mem_addr = 32'h10;
        mem_byte_size = 4; mem_wdata = 32'h0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready) cnt++;
        end
        mem_read_en = 0; mem_write_en = 0;
        @(posedge clk); @(negedge clk);
        chk("both_en_ready", 32'(cnt), 32'd0);
        do_chk("after_both", 0, 32'h10, 4, 0, 0, 32'hA1B255D4);

        // Reset during WAIT of a write: write lost, outputs cleared
        do_chk("pre_rst", 0, 32'h20, 4, 0, 0, 32'h99EF3344);
        mem_write_en = 1; mem_addr = 32'h20; mem_byte_size = 4; mem_wdata = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(mem_ready), 32'd0);
        chk("mid_rst_err", 32'(mem_err), 32'd0);
        chk("mid_rst_data", mem_data, 32'd0);
        mem_write_en = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_chk("post_rst", 0, 32'h20, 4, 0, 0, 32'h99EF3344);

        // Top of window and one past it
        do_chk("b_w0", 1, BASE, 4, 32'hCAFEF00D, 0, 32'h99EF3344);
        do_chk("b_wtop", 1, BASE + 32'hFFFC, 4, 32'h5A5A1234, 0, 32'h99EF3344);
        do_chk("b_rtop", 0, BASE + 32'hFFFC, 4, 0, 0, 32'h5A5A1234);
        do_chk("b_rhalf", 0, BASE + 32'hFFFE, 2, 0, 0, 32'h00005A5A);
`ifdef DIGITAL_MEM_BOUNDS_CHK_EN
        do_chk("b_rover", 0, BASE + 32'h10000, 4, 0, 1, 32'h0);
        do_chk("b_wover", 1, BASE + 32'h10000, 4, 32'h77777777, 1, 32'h0);
        do_chk("b_r0", 0, BASE, 4, 0, 0, 32'hCAFEF00D);
        model_last = 32'hCAFEF00D;
`else
        do_chk("b_rover", 0, BASE + 32'h10000, 4, 0, 0, 32'hCAFEF00D);
        do_chk("b_wover", 1, BASE + 32'h10000, 4, 32'h77777777, 0, 32'hCAFEF00D);
        do_chk("b_r0", 0, BASE, 4, 0, 0, 32'h77777777);
        model_last = 32'h77777777;
`endif

        // Random traffic in a prefilled window against the model
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model_op(1, 32'h100 + 32'(4*i), 4, wd, xe, xd);
            run_access(1, 32'h100 + 32'(4*i), 4, wd, 0, 2, r, e, d, lat, p);
        end
        for (int i = 0; i < 80; i++) begin
            a  = 32'h100 + 32'($urandom_range(0, 63));
            sz = sz_opts[$urandom_range(0, 7)];
            wd = $urandom;
            r  = 1'($urandom);
            model_op(r, a, sz, wd, xe, xd);
            run_access(r, a, sz, wd, $urandom_range(0, 2), 2, r, e, d, lat, p);
            chk($sformatf("rnd%0d_ready", i), 32'(p), 32'd1);
            chk($sformatf("rnd%0d_err", i), 32'(e), 32'(xe));
            chk($sformatf("rnd%0d_data", i), d, model_last);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
